// File: rtl/icache_responder.sv
// Direct-mapped, halfword-granular instruction cache for RV32IC fetch with byte-wide refill.
// Define ICACHE_STAT_EN to add saturating hit_cnt/miss_cnt outputs.
module icache_responder #(
  parameter int unsigned INDEX_BITS = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear_up,
  input  logic [31:0] pc,
  input  logic        start_fetch,
  output logic        fetch_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
`ifdef ICACHE_STAT_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [7:0]  mem_data
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W   = 31 - INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_FILL_LO, S_FILL_HI, S_RESP} state_e;

  state_e state_q, state_d;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [15:0]        data_q [ENTRIES];

  logic [31:0] a_q, a_d;
  logic [15:0] lo_data_q, lo_data_d;
  logic [7:0]  byte0_q, byte0_d;
  logic        byte_sel_q, byte_sel_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        fetch_ready_q, fetch_ready_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_addr_q, inst_addr_d;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
`endif

  // Lookup uses the live pc while idle, the latched address otherwise.
  logic [30:0]           lo_hw_c, hi_hw_c, fill_hw_c;
  logic [INDEX_BITS-1:0] lo_idx_c, hi_idx_c, fill_idx_c;
  logic                  lo_hit_c, hi_hit_c, lo_comp_c, new_comp_c;
  logic [15:0]           lo_rd_c, hi_rd_c, new_hw_c;
  logic                  byte_ack_c, fill_done_c, wr_en_c;

  assign lo_hw_c    = (state_q == S_IDLE) ? pc[31:1] : a_q[31:1];
  assign hi_hw_c    = lo_hw_c + 31'd1;
  assign fill_hw_c  = (state_q == S_FILL_HI) ? hi_hw_c : lo_hw_c;
  assign lo_idx_c   = lo_hw_c[INDEX_BITS-1:0];
  assign hi_idx_c   = hi_hw_c[INDEX_BITS-1:0];
  assign fill_idx_c = fill_hw_c[INDEX_BITS-1:0];
  assign lo_hit_c   = valid_q[lo_idx_c] && (tag_q[lo_idx_c] == lo_hw_c[30:INDEX_BITS]);
  assign hi_hit_c   = valid_q[hi_idx_c] && (tag_q[hi_idx_c] == hi_hw_c[30:INDEX_BITS]);
  assign lo_rd_c    = data_q[lo_idx_c];
  assign hi_rd_c    = data_q[hi_idx_c];
  assign lo_comp_c  = (lo_rd_c[1:0] != 2'b11);
  assign new_hw_c   = {mem_data, byte0_q};
  assign new_comp_c = (new_hw_c[1:0] != 2'b11);
  assign byte_ack_c = mem_req_q && mem_ready;
  assign fill_done_c = byte_ack_c && byte_sel_q;
  assign wr_en_c    = ((state_q == S_FILL_LO) || (state_q == S_FILL_HI)) && fill_done_c && !rob_clear_up;

  // State and datapath registers; everything freezes while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      valid_q       <= '0;
      a_q           <= '0;
      lo_data_q     <= '0;
      byte0_q       <= '0;
      byte_sel_q    <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      fetch_ready_q <= 1'b0;
      inst_q        <= '0;
      inst_addr_q   <= '0;
`ifdef ICACHE_STAT_EN
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
`endif
    end else if (rdy_in) begin
      state_q       <= state_d;
      a_q           <= a_d;
      lo_data_q     <= lo_data_d;
      byte0_q       <= byte0_d;
      byte_sel_q    <= byte_sel_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      fetch_ready_q <= fetch_ready_d;
      inst_q        <= inst_d;
      inst_addr_q   <= inst_addr_d;
`ifdef ICACHE_STAT_EN
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
`endif
      if (wr_en_c) valid_q[fill_idx_c] <= 1'b1;
    end
  end

  // Tag/data storage carries no reset; valid_q qualifies it.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && wr_en_c) begin
      tag_q[fill_idx_c]  <= fill_hw_c[30:INDEX_BITS];
      data_q[fill_idx_c] <= new_hw_c;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_fetch) begin
          if (lo_hit_c && (lo_comp_c || hi_hit_c)) state_d = S_RESP;
          else if (!lo_hit_c)                     state_d = S_FILL_LO;
          else                                    state_d = S_FILL_HI;
        end
      end
      S_FILL_LO: begin
        if (fill_done_c) state_d = (new_comp_c || hi_hit_c) ? S_RESP : S_FILL_HI;
      end
      S_FILL_HI: begin
        if (fill_done_c) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (rob_clear_up) state_d = S_IDLE;
  end

  always_comb begin
    a_d           = a_q;
    lo_data_d     = lo_data_q;
    byte0_d       = byte0_q;
    byte_sel_d    = byte_sel_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    fetch_ready_d = 1'b0;
    inst_d        = inst_q;
    inst_addr_d   = inst_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start_fetch && !rob_clear_up) begin
          a_d        = pc;
          lo_data_d  = lo_rd_c;
          byte_sel_d = 1'b0;
          if (state_d == S_RESP) begin
            fetch_ready_d = 1'b1;
            inst_addr_d   = pc;
            inst_d        = lo_comp_c ? {16'b0, lo_rd_c} : {hi_rd_c, lo_rd_c};
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = (state_d == S_FILL_LO) ? {lo_hw_c, 1'b0} : {hi_hw_c, 1'b0};
          end
        end
      end
      S_FILL_LO, S_FILL_HI: begin
        if (byte_ack_c) begin
          mem_req_d = 1'b0;
          if (!byte_sel_q) begin
            byte0_d    = mem_data;
            byte_sel_d = 1'b1;
          end else begin
            byte_sel_d = 1'b0;
            if (state_q == S_FILL_LO) lo_data_d = new_hw_c;
            if (state_d == S_RESP) begin
              fetch_ready_d = 1'b1;
              inst_addr_d   = a_q;
              if (state_q == S_FILL_HI) inst_d = {new_hw_c, lo_data_q};
              else if (new_comp_c)      inst_d = {16'b0, new_hw_c};
              else                      inst_d = {hi_rd_c, new_hw_c};
            end
          end
        end else if (!mem_req_q) begin
          // Request drops for a cycle after each ack before the next byte.
          mem_req_d  = 1'b1;
          mem_addr_d = {fill_hw_c, byte_sel_q};
        end
      end
      default: ;
    endcase
    if (rob_clear_up) begin
      mem_req_d     = 1'b0;
      fetch_ready_d = 1'b0;
      byte_sel_d    = 1'b0;
    end
  end

`ifdef ICACHE_STAT_EN
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_IDLE && state_d == S_RESP && hit_cnt_q != 32'hFFFF_FFFF)
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (state_q == S_IDLE && (state_d == S_FILL_LO || state_d == S_FILL_HI) &&
        miss_cnt_q != 32'hFFFF_FFFF)
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  assign fetch_ready = fetch_ready_q;
  assign inst        = inst_q;
  assign inst_addr   = inst_addr_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

endmodule
